bios_mem_ctrl: RTL

BIOS_MEM_CTRL -- requirements
Module: bios_mem_ctrl

---
 rtl/bios_mem_ctrl_pkg.sv | 18 +
 rtl/bios_mem_ctrl.sv | 98 +++++++++
 2 files changed

// File: rtl/bios_mem_ctrl_pkg.sv
// Shared definitions for the BIOS memory controller: default geometry,
// RAM read-port width and the FSM state encoding.
package bios_mem_ctrl_pkg;

    localparam int BIOS_ADDR_W    = 20;
    localparam int BIOS_DATA_W    = 32;
    localparam int BIOS_MEM_DEPTH = 128;
    localparam int BIOS_RAM_OUT_W = 48;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_CAPT  = 3'd2,
        WR       = 3'd3,
        DONE     = 3'd4
    } bios_state_e;

endpackage

// File: rtl/bios_mem_ctrl.sv
// CPU-side BIOS memory controller driving an external registered-read RAM.
// Optional macro BIOS_WRITE_PROTECT_EN rejects every write with err=1.
module bios_mem_ctrl
    import bios_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W    = BIOS_ADDR_W,
    parameter int DATA_W    = BIOS_DATA_W,
    parameter int MEM_DEPTH = BIOS_MEM_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req,
    input  logic                      we,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [DATA_W-1:0]         wdata,
    output logic                      ack,
    output logic [DATA_W-1:0]         rdata,
    output logic                      err,
    output logic                      busy,
    output logic [ADDR_W-1:0]         ram_addra,
    output logic [DATA_W-1:0]         ram_dina,
    output logic                      ram_wea,
    input  logic [BIOS_RAM_OUT_W-1:0] ram_douta
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    // Handshake: req/we/addr/wdata are sampled only on an edge where the FSM
    // is IDLE and req=1; ack is a one-cycle pulse in DONE, err/rdata valid with it.
    bios_state_e       r_state;
    bios_state_e       w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata;
    logic              w_oor;
    logic              w_reject;
    logic              w_unused;

    assign w_oor    = (addr > LAST_ADDR);
    assign w_unused = ^ram_douta[BIOS_RAM_OUT_W-1:DATA_W];

`ifdef BIOS_WRITE_PROTECT_EN
    assign w_reject = w_oor | we;
`else
    assign w_reject = w_oor;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (req) begin
                    if (w_reject)  w_state_nxt = DONE;
                    else if (we)   w_state_nxt = WR;
                    else           w_state_nxt = RD_ISSUE;
                end
            end
            RD_ISSUE: w_state_nxt = RD_CAPT;
            RD_CAPT:  w_state_nxt = DONE;
            WR:       w_state_nxt = DONE;
            DONE:     w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && req) begin
                r_addr  <= addr;
                r_wdata <= wdata;
                r_we    <= we;
                r_err   <= w_reject;
                if (w_reject) r_rdata <= '0;
            end
            // RAM output is valid one edge after RD_ISSUE presented the address
            if (r_state == RD_CAPT) r_rdata <= ram_douta[DATA_W-1:0];
        end
    end

    assign ack       = (r_state == DONE);
    assign err       = ack & r_err;
    assign rdata     = r_rdata;
    assign busy      = (r_state != IDLE);
    assign ram_addra = r_addr;
    assign ram_dina  = r_wdata;
    assign ram_wea   = (r_state == WR) & r_we;

endmodule
